voice_allocator: RTL and testbench

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

---
 rtl/synth_pkg.sv | 13 +
 rtl/voice_age_rank.sv | 51 +++++
 rtl/voice_allocator.sv | 169 ++++++++++++++++
 tb/tb_voice_allocator.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared constants and FSM state encoding for the synth voice path.
package synth_pkg;

  localparam int unsigned MIDI_W           = 7;
  localparam int unsigned N_VOICES_DEFAULT = 4;

  // Allocator FSM: IDLE accepts events, KILL holds a victim voice low for one cycle.
  typedef enum logic {
    StIdle = 1'b0,
    StKill = 1'b1
  } alloc_state_e;

endpackage

// File: rtl/voice_age_rank.sv
// Per-voice age ranks (0 = newest). Ranks always form a permutation of 0..N_VOICES-1.
module voice_age_rank #(
  parameter int unsigned N_VOICES = 4,
  parameter int unsigned IDX_W    = (N_VOICES > 1) ? $clog2(N_VOICES) : 1
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_upd,
  input  logic [IDX_W-1:0] i_idx,
  output logic [IDX_W-1:0] o_oldest
);

  logic [IDX_W-1:0] r_rank [N_VOICES];
  logic [IDX_W-1:0] w_rank_old;
  logic [IDX_W-1:0] w_oldest;

  // Old rank of the voice being promoted to newest.
  always_comb begin
    w_rank_old = r_rank[i_idx];
  end

  // Promote the assigned voice to rank 0; everything younger than it ages by one.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      for (int v = 0; v < N_VOICES; v++) begin
        r_rank[v] <= IDX_W'(v);
      end
    end else if (i_upd) begin
      for (int v = 0; v < N_VOICES; v++) begin
        if (IDX_W'(v) == i_idx) begin
          r_rank[v] <= '0;
        end else if (r_rank[v] < w_rank_old) begin
          r_rank[v] <= r_rank[v] + IDX_W'(1);
        end
      end
    end
  end

  // The voice carrying the highest rank is the steal candidate.
  always_comb begin
    w_oldest = '0;
    for (int v = 0; v < N_VOICES; v++) begin
      if (r_rank[v] == IDX_W'(N_VOICES - 1)) begin
        w_oldest = IDX_W'(v);
      end
    end
  end

  assign o_oldest = w_oldest;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note-on/off events onto N_VOICES phase_bank voices,
// retriggering held notes and stealing the oldest voice when all are busy.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int unsigned N_VOICES = N_VOICES_DEFAULT
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  input  logic                       i_note_on,
  input  logic [MIDI_W-1:0]          i_midi,
  output logic                       o_ready,
  output logic [N_VOICES-1:0]        o_cmd,
  output logic [MIDI_W*N_VOICES-1:0] o_midi,
  output logic                       o_steal
);

  localparam int unsigned IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;

  alloc_state_e                r_state;
  alloc_state_e                w_state_d;
  logic [N_VOICES-1:0]         r_cmd;
  logic [N_VOICES-1:0]         w_cmd_d;
  logic [MIDI_W*N_VOICES-1:0]  r_midi;
  logic [MIDI_W*N_VOICES-1:0]  w_midi_d;
  logic                        r_steal;
  logic                        w_steal_d;
  logic                        r_ready;
  logic                        w_ready_d;
  logic [IDX_W-1:0]            r_kill_idx;
  logic [IDX_W-1:0]            w_kill_idx_d;

  logic                        w_accept;
  logic                        w_match;
  logic [IDX_W-1:0]            w_match_idx;
  logic                        w_free;
  logic [IDX_W-1:0]            w_free_idx;
  logic [IDX_W-1:0]            w_oldest;
  logic                        w_upd;
  logic [IDX_W-1:0]            w_upd_idx;

  assign w_accept = i_valid && r_ready;

  // Look up an active voice already holding the note and the lowest-index idle voice.
  always_comb begin
    w_match     = 1'b0;
    w_match_idx = '0;
    w_free      = 1'b0;
    w_free_idx  = '0;
    for (int v = 0; v < N_VOICES; v++) begin
      if (r_cmd[v] && (r_midi[v*MIDI_W +: MIDI_W] == i_midi)) begin
        w_match     = 1'b1;
        w_match_idx = IDX_W'(v);
      end
    end
    // Scan downwards so the lowest inactive index is the one left standing.
    for (int v = N_VOICES - 1; v >= 0; v--) begin
      if (!r_cmd[v]) begin
        w_free     = 1'b1;
        w_free_idx = IDX_W'(v);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM next state: retrigger and steal both need the one-cycle low pulse in KILL.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept && i_note_on && (w_match || !w_free)) begin
          w_state_d = StKill;
        end
      end
      StKill:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // FSM outputs: next values of the registered voice commands, notes and steal pulse.
  always_comb begin
    w_cmd_d      = r_cmd;
    w_midi_d     = r_midi;
    w_steal_d    = 1'b0;
    w_kill_idx_d = r_kill_idx;
    w_upd        = 1'b0;
    w_upd_idx    = '0;
    w_ready_d    = (w_state_d == StIdle);
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (i_note_on) begin
            if (w_match) begin
              // Held note: drop the gate for a cycle so the phase restarts.
              w_cmd_d[w_match_idx] = 1'b0;
              w_kill_idx_d         = w_match_idx;
              w_upd                = 1'b1;
              w_upd_idx            = w_match_idx;
            end else if (w_free) begin
              w_cmd_d[w_free_idx]                   = 1'b1;
              w_midi_d[w_free_idx*MIDI_W +: MIDI_W] = i_midi;
              w_upd                                 = 1'b1;
              w_upd_idx                             = w_free_idx;
            end else begin
              w_cmd_d[w_oldest]                   = 1'b0;
              w_midi_d[w_oldest*MIDI_W +: MIDI_W] = i_midi;
              w_steal_d                           = 1'b1;
              w_kill_idx_d                        = w_oldest;
              w_upd                               = 1'b1;
              w_upd_idx                           = w_oldest;
            end
          end else if (w_match) begin
            // Note-off leaves the note field and age ranks untouched.
            w_cmd_d[w_match_idx] = 1'b0;
          end
        end
      end
      StKill: begin
        w_cmd_d[r_kill_idx] = 1'b1;
      end
      default: begin
        w_cmd_d = r_cmd;
      end
    endcase
  end

  // Output and victim registers.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_cmd      <= '0;
      r_midi     <= '0;
      r_steal    <= 1'b0;
      r_ready    <= 1'b1;
      r_kill_idx <= '0;
    end else begin
      r_cmd      <= w_cmd_d;
      r_midi     <= w_midi_d;
      r_steal    <= w_steal_d;
      r_ready    <= w_ready_d;
      r_kill_idx <= w_kill_idx_d;
    end
  end

  voice_age_rank #(
    .N_VOICES (N_VOICES),
    .IDX_W    (IDX_W)
  ) u_age_rank (
    .clk      (clk),
    .i_rst    (i_rst),
    .i_upd    (w_upd),
    .i_idx    (w_upd_idx),
    .o_oldest (w_oldest)
  );

  assign o_ready = r_ready;
  assign o_cmd   = r_cmd;
  assign o_midi  = r_midi;
  assign o_steal = r_steal;

endmodule

// File: tb/tb_voice_allocator.sv
// Scenario bench for voice_allocator (N_VOICES = 4).
module tb_voice_allocator;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        i_note_on;
  logic [6:0]  i_midi;
  logic        o_ready;
  logic [3:0]  o_cmd;
  logic [27:0] o_midi;
  logic        o_steal;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        rst;
    logic        valid;
    logic        on;
    logic [6:0]  note;
    logic [3:0]  cmd;
    logic [27:0] midi;
    logic        steal;
    logic        ready;
  } step_t;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [27:0] midi;
    logic        steal;
    logic        ready;
  } exp_t;

  exp_t exp_q[$];

  voice_allocator #(
    .N_VOICES (4)
  ) dut (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .i_note_on (i_note_on),
    .i_midi    (i_midi),
    .o_ready   (o_ready),
    .o_cmd     (o_cmd),
    .o_midi    (o_midi),
    .o_steal   (o_steal)
  );

  always #5 clk = ~clk;

  function automatic step_t mk(input logic rst, input logic valid, input logic on,
                               input logic [6:0] note, input logic [3:0] cmd,
                               input logic [27:0] midi, input logic steal, input logic ready);
    step_t s;
    s.rst   = rst;
    s.valid = valid;
    s.on    = on;
    s.note  = note;
    s.cmd   = cmd;
    s.midi  = midi;
    s.steal = steal;
    s.ready = ready;
    return s;
  endfunction

  // Drive one cycle of stimulus, queue its expected outcome, sample 1 ns after the edge.
  task automatic apply(input step_t s);
    exp_t e;
    i_rst     = s.rst;
    i_valid   = s.valid;
    i_note_on = s.on;
    i_midi    = s.note;
    e.cmd     = s.cmd;
    e.midi    = s.midi;
    e.steal   = s.steal;
    e.ready   = s.ready;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(H, L, L, 7'h00, 4'b0000, 28'h0, L, H));
    s.push_back(mk(H, H, H, 7'h11, 4'b0000, 28'h0, L, H));  // event dropped under reset
    s.push_back(mk(L, L, L, 7'h00, 4'b0000, 28'h0, L, H));
    foreach (s[i]) begin
      apply(s[i]);
      e = exp_q.pop_front();
      n_tests++;
      if ({o_cmd, o_midi, o_steal, o_ready} !== e) begin
        n_fail++;
        $display("FAIL reset[%0d]: got cmd=%b midi=%h steal=%b ready=%b, want cmd=%b midi=%h steal=%b ready=%b",
                 i, o_cmd, o_midi, o_steal, o_ready, e.cmd, e.midi, e.steal, e.ready);
      end
    end
  endtask

  task automatic test_single_note();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(H, L, L, 7'h00, 4'b0000, 28'h0, L, H));
    s.push_back(mk(L, H, H, 7'h45, 4'b0001, {21'h0, 7'h45}, L, H));
    s.push_back(mk(L, L, L, 7'h00, 4'b0001, {21'h0, 7'h45}, L, H));
    s.push_back(mk(L, H, L, 7'h45, 4'b0000, {21'h0, 7'h45}, L, H));
    s.push_back(mk(L, H, L, 7'h45, 4'b0000, {21'h0, 7'h45}, L, H));  // nothing left to release
    foreach (s[i]) begin
      apply(s[i]);
      e = exp_q.pop_front();
      n_tests++;
      if ({o_cmd, o_midi, o_steal, o_ready} !== e) begin
        n_fail++;
        $display("FAIL single_note[%0d]: got cmd=%b midi=%h steal=%b ready=%b, want cmd=%b midi=%h steal=%b ready=%b",
                 i, o_cmd, o_midi, o_steal, o_ready, e.cmd, e.midi, e.steal, e.ready);
      end
    end
  endtask

  task automatic test_steal();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(H, L, L, 7'h00, 4'b0000, 28'h0, L, H));
    s.push_back(mk(L, H, H, 7'h3c, 4'b0001, {7'h00, 7'h00, 7'h00, 7'h3c}, L, H));
    s.push_back(mk(L, H, H, 7'h40, 4'b0011, {7'h00, 7'h00, 7'h40, 7'h3c}, L, H));
    s.push_back(mk(L, H, H, 7'h43, 4'b0111, {7'h00, 7'h43, 7'h40, 7'h3c}, L, H));
    s.push_back(mk(L, H, H, 7'h48, 4'b1111, {7'h48, 7'h43, 7'h40, 7'h3c}, L, H));
    s.push_back(mk(L, H, H, 7'h4c, 4'b1110, {7'h48, 7'h43, 7'h40, 7'h4c}, H, L));
    s.push_back(mk(L, H, H, 7'h22, 4'b1111, {7'h48, 7'h43, 7'h40, 7'h4c}, L, H));  // ignored in KILL
    s.push_back(mk(L, L, L, 7'h00, 4'b1111, {7'h48, 7'h43, 7'h40, 7'h4c}, L, H));
    // Voice 1 is now the oldest.
    s.push_back(mk(L, H, H, 7'h55, 4'b1101, {7'h48, 7'h43, 7'h55, 7'h4c}, H, L));
    s.push_back(mk(L, L, L, 7'h00, 4'b1111, {7'h48, 7'h43, 7'h55, 7'h4c}, L, H));
    foreach (s[i]) begin
      apply(s[i]);
      e = exp_q.pop_front();
      n_tests++;
      if ({o_cmd, o_midi, o_steal, o_ready} !== e) begin
        n_fail++;
        $display("FAIL steal[%0d]: got cmd=%b midi=%h steal=%b ready=%b, want cmd=%b midi=%h steal=%b ready=%b",
                 i, o_cmd, o_midi, o_steal, o_ready, e.cmd, e.midi, e.steal, e.ready);
      end
    end
  endtask

  task automatic test_retrigger();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(H, L, L, 7'h00, 4'b0000, 28'h0, L, H));
    s.push_back(mk(L, H, H, 7'h3c, 4'b0001, {7'h00, 7'h00, 7'h00, 7'h3c}, L, H));
    s.push_back(mk(L, H, H, 7'h40, 4'b0011, {7'h00, 7'h00, 7'h40, 7'h3c}, L, H));
    s.push_back(mk(L, H, H, 7'h3c, 4'b0010, {7'h00, 7'h00, 7'h40, 7'h3c}, L, L));
    s.push_back(mk(L, L, L, 7'h00, 4'b0011, {7'h00, 7'h00, 7'h40, 7'h3c}, L, H));
    s.push_back(mk(L, L, L, 7'h00, 4'b0011, {7'h00, 7'h00, 7'h40, 7'h3c}, L, H));
    foreach (s[i]) begin
      apply(s[i]);
      e = exp_q.pop_front();
      n_tests++;
      if ({o_cmd, o_midi, o_steal, o_ready} !== e) begin
        n_fail++;
        $display("FAIL retrigger[%0d]: got cmd=%b midi=%h steal=%b ready=%b, want cmd=%b midi=%h steal=%b ready=%b",
                 i, o_cmd, o_midi, o_steal, o_ready, e.cmd, e.midi, e.steal, e.ready);
      end
    end
  endtask

  task automatic test_note_off();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(H, L, L, 7'h00, 4'b0000, 28'h0, L, H));
    s.push_back(mk(L, H, H, 7'h3c, 4'b0001, {7'h00, 7'h00, 7'h00, 7'h3c}, L, H));
    s.push_back(mk(L, H, H, 7'h40, 4'b0011, {7'h00, 7'h00, 7'h40, 7'h3c}, L, H));
    s.push_back(mk(L, H, H, 7'h43, 4'b0111, {7'h00, 7'h43, 7'h40, 7'h3c}, L, H));
    s.push_back(mk(L, H, H, 7'h48, 4'b1111, {7'h48, 7'h43, 7'h40, 7'h3c}, L, H));
    s.push_back(mk(L, H, L, 7'h40, 4'b1101, {7'h48, 7'h43, 7'h40, 7'h3c}, L, H));
    s.push_back(mk(L, H, H, 7'h50, 4'b1111, {7'h48, 7'h43, 7'h50, 7'h3c}, L, H));
    s.push_back(mk(L, H, L, 7'h7f, 4'b1111, {7'h48, 7'h43, 7'h50, 7'h3c}, L, H));
    s.push_back(mk(L, H, L, 7'h3c, 4'b1110, {7'h48, 7'h43, 7'h50, 7'h3c}, L, H));
    s.push_back(mk(L, H, L, 7'h3c, 4'b1110, {7'h48, 7'h43, 7'h50, 7'h3c}, L, H));
    foreach (s[i]) begin
      apply(s[i]);
      e = exp_q.pop_front();
      n_tests++;
      if ({o_cmd, o_midi, o_steal, o_ready} !== e) begin
        n_fail++;
        $display("FAIL note_off[%0d]: got cmd=%b midi=%h steal=%b ready=%b, want cmd=%b midi=%h steal=%b ready=%b",
                 i, o_cmd, o_midi, o_steal, o_ready, e.cmd, e.midi, e.steal, e.ready);
      end
    end
  endtask

  task automatic test_note_extremes();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(H, L, L, 7'h00, 4'b0000, 28'h0, L, H));
    s.push_back(mk(L, H, H, 7'h7f, 4'b0001, {7'h00, 7'h00, 7'h00, 7'h7f}, L, H));
    s.push_back(mk(L, H, H, 7'h00, 4'b0011, {7'h00, 7'h00, 7'h00, 7'h7f}, L, H));
    s.push_back(mk(L, H, H, 7'h00, 4'b0001, {7'h00, 7'h00, 7'h00, 7'h7f}, L, L));
    s.push_back(mk(L, L, L, 7'h00, 4'b0011, {7'h00, 7'h00, 7'h00, 7'h7f}, L, H));
    s.push_back(mk(L, H, L, 7'h7f, 4'b0010, {7'h00, 7'h00, 7'h00, 7'h7f}, L, H));
    foreach (s[i]) begin
      apply(s[i]);
      e = exp_q.pop_front();
      n_tests++;
      if ({o_cmd, o_midi, o_steal, o_ready} !== e) begin
        n_fail++;
        $display("FAIL extremes[%0d]: got cmd=%b midi=%h steal=%b ready=%b, want cmd=%b midi=%h steal=%b ready=%b",
                 i, o_cmd, o_midi, o_steal, o_ready, e.cmd, e.midi, e.steal, e.ready);
      end
    end
  endtask

  task automatic test_reset_in_kill();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(H, L, L, 7'h00, 4'b0000, 28'h0, L, H));
    s.push_back(mk(L, H, H, 7'h3c, 4'b0001, {7'h00, 7'h00, 7'h00, 7'h3c}, L, H));
    s.push_back(mk(L, H, H, 7'h40, 4'b0011, {7'h00, 7'h00, 7'h40, 7'h3c}, L, H));
    s.push_back(mk(L, H, H, 7'h43, 4'b0111, {7'h00, 7'h43, 7'h40, 7'h3c}, L, H));
    s.push_back(mk(L, H, H, 7'h48, 4'b1111, {7'h48, 7'h43, 7'h40, 7'h3c}, L, H));
    s.push_back(mk(L, H, H, 7'h4c, 4'b1110, {7'h48, 7'h43, 7'h40, 7'h4c}, H, L));
    s.push_back(mk(H, L, L, 7'h00, 4'b0000, 28'h0, L, H));  // retrigger aborted
    s.push_back(mk(L, L, L, 7'h00, 4'b0000, 28'h0, L, H));
    s.push_back(mk(L, H, H, 7'h61, 4'b0001, {7'h00, 7'h00, 7'h00, 7'h61}, L, H));
    foreach (s[i]) begin
      apply(s[i]);
      e = exp_q.pop_front();
      n_tests++;
      if ({o_cmd, o_midi, o_steal, o_ready} !== e) begin
        n_fail++;
        $display("FAIL reset_in_kill[%0d]: got cmd=%b midi=%h steal=%b ready=%b, want cmd=%b midi=%h steal=%b ready=%b",
                 i, o_cmd, o_midi, o_steal, o_ready, e.cmd, e.midi, e.steal, e.ready);
      end
    end
  endtask

  initial begin
    i_rst     = 1'b1;
    i_valid   = 1'b0;
    i_note_on = 1'b0;
    i_midi    = 7'h00;
    test_reset();
    test_single_note();
    test_steal();
    test_retrigger();
    test_note_off();
    test_note_extremes();
    test_reset_in_kill();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

endmodule
